// File: rtl/gray_ptr_counter.sv
// One side of an async FIFO: binary/Gray pointer pair plus a registered Full
// (write side) or Empty (read side) flag. Define GRAY_PTR_LEVEL_EN to add o_level.
module gray_ptr_counter #(
    parameter int ADDR_WIDTH = 4,
    parameter bit WRITE_SIDE = 1'b1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_inc,
    input  logic [ADDR_WIDTH:0]   i_sync_gray_ptr,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic [ADDR_WIDTH:0]   o_gray_ptr,
`ifdef GRAY_PTR_LEVEL_EN
    output logic [ADDR_WIDTH:0]   o_level,
`endif
    output logic                  o_flag
);
    localparam int PW = ADDR_WIDTH + 1;
    // One full lap apart shows up in Gray code as the top two bits inverted.
    localparam logic [PW-1:0] LAP_MASK = PW'(3) << (PW - 2);

    logic [PW-1:0] r_bin;
    logic [PW-1:0] r_gray;
    logic          r_flag;

    logic          w_accept;
    logic [PW-1:0] w_bin_next;
    logic [PW-1:0] w_gray_next;
    logic [PW-1:0] w_full_target;
    logic          w_flag_next;

    assign w_accept      = i_inc & ~r_flag;
    assign w_bin_next    = r_bin + PW'(w_accept);
    assign w_gray_next   = w_bin_next ^ (w_bin_next >> 1);
    assign w_full_target = i_sync_gray_ptr ^ LAP_MASK;

    // Compared every cycle so a moving opposite pointer alone can clear the flag.
    assign w_flag_next = WRITE_SIDE ? (w_gray_next == w_full_target)
                                    : (w_gray_next == i_sync_gray_ptr);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_bin  <= '0;
            r_gray <= '0;
            r_flag <= ~WRITE_SIDE;
        end else begin
            r_bin  <= w_bin_next;
            r_gray <= w_gray_next;
            r_flag <= w_flag_next;
        end
    end

    assign o_addr     = r_bin[ADDR_WIDTH-1:0];
    assign o_gray_ptr = r_gray;
    assign o_flag     = r_flag;

`ifdef GRAY_PTR_LEVEL_EN
    logic [PW-1:0] w_sync_bin;
    logic [PW-1:0] w_level_next;
    logic [PW-1:0] r_level;

    // Each binary bit is the XOR of the Gray bits from itself up to the MSB.
    generate
        for (genvar gi = 0; gi < PW; gi++) begin : g_sync_bin
            assign w_sync_bin[gi] = ^i_sync_gray_ptr[PW-1:gi];
        end
    endgenerate

    assign w_level_next = WRITE_SIDE ? (w_bin_next - w_sync_bin)
                                     : (w_sync_bin - w_bin_next);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_level <= '0;
        end else begin
            r_level <= w_level_next;
        end
    end

    assign o_level = r_level;
`endif

endmodule

// File: tb/tb_gray_ptr_counter.sv
// Bench for gray_ptr_counter: one write-side and one read-side instance checked
// against an occupancy-based reference model.
module tb_gray_ptr_counter;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_inc = 1'b0, rd_inc = 1'b0;
    logic [4:0] wr_sync = '0, rd_sync = '0;
    logic [3:0] wr_addr, rd_addr;
    logic [4:0] wr_gray, rd_gray;
    logic       wr_flag, rd_flag;
    logic [4:0] wr_level, rd_level;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: pointers as plain integers, flags from occupancy.
    int m_wbin = 0, m_rbin = 0;
    int m_wlevel = 0, m_rlevel = 0;
    bit m_wflag = 1'b0, m_rflag = 1'b1;
    bit m_wacc = 1'b0, m_racc = 1'b0;

    always #5 clk = ~clk;

    gray_ptr_counter #(.ADDR_WIDTH(4), .WRITE_SIDE(1'b1)) u_wr (
        .i_clk(clk), .i_rst(rst), .i_inc(wr_inc), .i_sync_gray_ptr(wr_sync),
        .o_addr(wr_addr), .o_gray_ptr(wr_gray),
`ifdef GRAY_PTR_LEVEL_EN
        .o_level(wr_level),
`endif
        .o_flag(wr_flag)
    );

    gray_ptr_counter #(.ADDR_WIDTH(4), .WRITE_SIDE(1'b0)) u_rd (
        .i_clk(clk), .i_rst(rst), .i_inc(rd_inc), .i_sync_gray_ptr(rd_sync),
        .o_addr(rd_addr), .o_gray_ptr(rd_gray),
`ifdef GRAY_PTR_LEVEL_EN
        .o_level(rd_level),
`endif
        .o_flag(rd_flag)
    );

`ifndef GRAY_PTR_LEVEL_EN
    assign wr_level = '0;
    assign rd_level = '0;
`endif

    function automatic logic [4:0] to_gray(input logic [4:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic model_reset();
        m_wbin = 0; m_rbin = 0; m_wlevel = 0; m_rlevel = 0;
        m_wflag = 1'b0; m_rflag = 1'b1; m_wacc = 1'b0; m_racc = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        wr_inc = 1'b0; rd_inc = 1'b0; wr_sync = '0; rd_sync = '0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // One clock: drive inputs, advance the model, settle past the edge.
    task automatic step(input bit wi, input int wsb, input bit ri, input int rsb);
        wr_inc = wi; wr_sync = to_gray(5'(wsb));
        rd_inc = ri; rd_sync = to_gray(5'(rsb));
        @(posedge clk);
        m_wacc   = wi && !m_wflag;
        m_wbin   = (m_wbin + int'(m_wacc)) % 32;
        m_wlevel = (m_wbin - wsb + 64) % 32;
        m_wflag  = (m_wlevel == 16);
        m_racc   = ri && !m_rflag;
        m_rbin   = (m_rbin + int'(m_racc)) % 32;
        m_rlevel = (rsb - m_rbin + 64) % 32;
        m_rflag  = (m_rbin == rsb);
        #1;
        $display("t=%0t wr: inc=%0b sync_bin=%0d -> gray=%b flag=%0b | rd: inc=%0b sync_bin=%0d -> gray=%b flag=%0b",
                 $time, wi, wsb, wr_gray, wr_flag, ri, rsb, rd_gray, rd_flag);
    endtask

    task automatic test_reset();
        wr_inc = 1'b1; rd_inc = 1'b1; wr_sync = 5'b00011; rd_sync = 5'b00011;
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        n_checks++; if (wr_addr !== 4'd0) begin n_errors++; $display("FAIL reset_wr_addr: got %0d expected 0", wr_addr); end
        n_checks++; if (wr_gray !== 5'b00000) begin n_errors++; $display("FAIL reset_wr_gray: got %b expected 00000", wr_gray); end
        n_checks++; if (wr_flag !== 1'b0) begin n_errors++; $display("FAIL reset_wr_flag: got %b expected 0", wr_flag); end
        n_checks++; if (rd_addr !== 4'd0) begin n_errors++; $display("FAIL reset_rd_addr: got %0d expected 0", rd_addr); end
        n_checks++; if (rd_gray !== 5'b00000) begin n_errors++; $display("FAIL reset_rd_gray: got %b expected 00000", rd_gray); end
        n_checks++; if (rd_flag !== 1'b1) begin n_errors++; $display("FAIL reset_rd_flag: got %b expected 1", rd_flag); end
`ifdef GRAY_PTR_LEVEL_EN
        n_checks++; if (wr_level !== 5'd0) begin n_errors++; $display("FAIL reset_wr_level: got %0d expected 0", wr_level); end
        n_checks++; if (rd_level !== 5'd0) begin n_errors++; $display("FAIL reset_rd_level: got %0d expected 0", rd_level); end
`endif
        @(posedge clk);
        #1;
        n_checks++; if (wr_gray !== 5'b00000) begin n_errors++; $display("FAIL reset_hold_wr_gray: got %b expected 00000", wr_gray); end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        step(1'b1, 0, 1'b0, 0);
        n_checks++; if (wr_addr !== 4'd1) begin n_errors++; $display("FAIL reset_first_accept_addr: got %0d expected 1", wr_addr); end
        n_checks++; if (wr_gray !== 5'b00001) begin n_errors++; $display("FAIL reset_first_accept_gray: got %b expected 00001", wr_gray); end
    endtask

    task automatic test_write_fill();
        logic [4:0] prev;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            n_checks++; if (wr_addr !== 4'(i)) begin n_errors++; $display("FAIL fill_addr[%0d]: got %0d expected %0d", i, wr_addr, i); end
            prev = wr_gray;
            step(1'b1, 0, 1'b0, 0);
            n_checks++; if (wr_gray !== to_gray(5'(m_wbin))) begin n_errors++; $display("FAIL fill_gray[%0d]: got %b expected %b", i, wr_gray, to_gray(5'(m_wbin))); end
            n_checks++; if ($countones(wr_gray ^ prev) != 1) begin n_errors++; $display("FAIL fill_one_bit[%0d]: got %b after %b", i, wr_gray, prev); end
            n_checks++; if (wr_flag !== (i == 15)) begin n_errors++; $display("FAIL fill_full[%0d]: got %b expected %b", i, wr_flag, i == 15); end
        end
        n_checks++; if (wr_gray !== 5'b11000) begin n_errors++; $display("FAIL fill_final_gray: got %b expected 11000", wr_gray); end
`ifdef GRAY_PTR_LEVEL_EN
        n_checks++; if (wr_level !== 5'd16) begin n_errors++; $display("FAIL fill_level: got %0d expected 16", wr_level); end
`endif
        step(1'b1, 0, 1'b0, 0);
        n_checks++; if (wr_gray !== 5'b11000) begin n_errors++; $display("FAIL fill_17th_gray: got %b expected 11000", wr_gray); end
        n_checks++; if (wr_flag !== 1'b1) begin n_errors++; $display("FAIL fill_17th_full: got %b expected 1", wr_flag); end
    endtask

    task automatic test_full_release();
        step(1'b0, 1, 1'b0, 0);
        n_checks++; if (wr_flag !== 1'b0) begin n_errors++; $display("FAIL release_full: got %b expected 0", wr_flag); end
        n_checks++; if (wr_gray !== 5'b11000) begin n_errors++; $display("FAIL release_gray: got %b expected 11000", wr_gray); end
`ifdef GRAY_PTR_LEVEL_EN
        n_checks++; if (wr_level !== 5'd15) begin n_errors++; $display("FAIL release_level: got %0d expected 15", wr_level); end
`endif
    endtask

    task automatic test_simultaneous();
        step(1'b1, 2, 1'b0, 0);
        n_checks++; if (wr_flag !== 1'b0) begin n_errors++; $display("FAIL simul_full: got %b expected 0", wr_flag); end
        n_checks++; if (wr_gray !== to_gray(5'(m_wbin))) begin n_errors++; $display("FAIL simul_gray: got %b expected %b", wr_gray, to_gray(5'(m_wbin))); end
`ifdef GRAY_PTR_LEVEL_EN
        n_checks++; if (wr_level !== 5'd15) begin n_errors++; $display("FAIL simul_level: got %0d expected 15", wr_level); end
`endif
    endtask

    task automatic test_read_empty();
        logic [4:0] exp_gray [4] = '{5'b00000, 5'b00001, 5'b00011, 5'b00011};
        logic       exp_flag [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 0, 1'b1, 0);
            n_checks++; if (rd_gray !== 5'b00000) begin n_errors++; $display("FAIL empty_hold_gray[%0d]: got %b expected 00000", i, rd_gray); end
            n_checks++; if (rd_flag !== 1'b1) begin n_errors++; $display("FAIL empty_hold_flag[%0d]: got %b expected 1", i, rd_flag); end
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 0, 1'b1, 2);
            n_checks++; if (rd_gray !== exp_gray[i] || rd_gray !== to_gray(5'(m_rbin))) begin n_errors++; $display("FAIL empty_read_gray[%0d]: got %b expected %b", i, rd_gray, exp_gray[i]); end
            n_checks++; if (rd_flag !== exp_flag[i] || rd_flag !== m_rflag) begin n_errors++; $display("FAIL empty_read_flag[%0d]: got %b expected %b", i, rd_flag, exp_flag[i]); end
`ifdef GRAY_PTR_LEVEL_EN
            n_checks++; if (rd_level !== 5'(m_rlevel)) begin n_errors++; $display("FAIL empty_read_level[%0d]: got %0d expected %0d", i, rd_level, m_rlevel); end
`endif
        end
    endtask

    task automatic test_wrap();
        logic [4:0] wprev, rprev;
        int pw, pr, wacc_n = 0, racc_n = 0, wwraps = 0, rwraps = 0, wsb, rsb;
        bit wi, ri;
        do_reset();
        for (int cyc = 0; cyc < 600 && (wacc_n < 40 || racc_n < 40); cyc++) begin
            wi  = ($urandom_range(0, 3) != 0);
            ri  = ($urandom_range(0, 3) != 0);
            wsb = (m_wbin - int'($urandom_range(0, 16)) + 32) % 32;
            rsb = (m_rbin + int'($urandom_range(0, 16))) % 32;
            wprev = wr_gray; rprev = rd_gray; pw = m_wbin; pr = m_rbin;
            step(wi, wsb, ri, rsb);
            wacc_n += int'(m_wacc); racc_n += int'(m_racc);
            n_checks++; if (wr_addr !== 4'(m_wbin) || wr_gray !== to_gray(5'(m_wbin))) begin n_errors++; $display("FAIL wrap_wr_ptr: got addr=%0d gray=%b expected addr=%0d gray=%b", wr_addr, wr_gray, 4'(m_wbin), to_gray(5'(m_wbin))); end
            n_checks++; if (wr_flag !== m_wflag) begin n_errors++; $display("FAIL wrap_wr_full: got %b expected %b", wr_flag, m_wflag); end
            n_checks++; if ($countones(wr_gray ^ wprev) != int'(m_wacc)) begin n_errors++; $display("FAIL wrap_wr_step: got %b after %b, accept=%0b", wr_gray, wprev, m_wacc); end
            n_checks++; if (rd_addr !== 4'(m_rbin) || rd_gray !== to_gray(5'(m_rbin))) begin n_errors++; $display("FAIL wrap_rd_ptr: got addr=%0d gray=%b expected addr=%0d gray=%b", rd_addr, rd_gray, 4'(m_rbin), to_gray(5'(m_rbin))); end
            n_checks++; if (rd_flag !== m_rflag) begin n_errors++; $display("FAIL wrap_rd_empty: got %b expected %b", rd_flag, m_rflag); end
            n_checks++; if ($countones(rd_gray ^ rprev) != int'(m_racc)) begin n_errors++; $display("FAIL wrap_rd_step: got %b after %b, accept=%0b", rd_gray, rprev, m_racc); end
`ifdef GRAY_PTR_LEVEL_EN
            n_checks++; if (wr_level !== 5'(m_wlevel)) begin n_errors++; $display("FAIL wrap_wr_level: got %0d expected %0d", wr_level, m_wlevel); end
            n_checks++; if (rd_level !== 5'(m_rlevel)) begin n_errors++; $display("FAIL wrap_rd_level: got %0d expected %0d", rd_level, m_rlevel); end
`endif
            if (pw == 31 && m_wbin == 0) begin
                wwraps++;
                n_checks++; if (wprev !== 5'b10000 || wr_gray !== 5'b00000) begin n_errors++; $display("FAIL wrap_wr_edge: got %b -> %b expected 10000 -> 00000", wprev, wr_gray); end
            end
            if (pr == 31 && m_rbin == 0) begin
                rwraps++;
                n_checks++; if (rprev !== 5'b10000 || rd_gray !== 5'b00000) begin n_errors++; $display("FAIL wrap_rd_edge: got %b -> %b expected 10000 -> 00000", rprev, rd_gray); end
            end
        end
        n_checks++; if (wacc_n < 32 || wwraps < 1) begin n_errors++; $display("FAIL wrap_wr_budget: got %0d accepts %0d wraps expected >=32 and >=1", wacc_n, wwraps); end
        n_checks++; if (racc_n < 32 || rwraps < 1) begin n_errors++; $display("FAIL wrap_rd_budget: got %0d accepts %0d wraps expected >=32 and >=1", racc_n, rwraps); end
    endtask

    initial begin
        #2;
        test_reset();
        test_write_fill();
        test_full_release();
        test_simultaneous();
        test_read_empty();
        test_wrap();
        test_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
